// File: rtl/drop_sequencer.sv
// Baggage-drop sequencer: arm/abort handling, weight-hold qualification, timed hatch window, cooldown, drop counter.
// All outputs registered (one cycle after the deciding edge); no backpressure, commands are sampled every cycle.
module drop_sequencer #(
   parameter int W               = 16,
   parameter int HOLD_CYCLES     = 8,
   parameter int OPEN_CYCLES     = 16,
   parameter int COOLDOWN_CYCLES = 4,
   parameter int ARM_TIMEOUT     = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   input  logic         cmd_drop,
   input  logic         cmd_abort,
   input  logic [W-1:0] t_act,
   input  logic [W-1:0] t_lim,
   output logic         drop_en,
   output logic         hatch_open,
   output logic         drop_done,
   output logic         timeout,
   output logic         busy,
   output logic [7:0]   drop_count,
   output logic [1:0]   state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_OPEN  = 2'd2,
      S_COOL  = 2'd3
   } st_t;

   localparam int MAX_HT = (HOLD_CYCLES > ARM_TIMEOUT) ? HOLD_CYCLES : ARM_TIMEOUT;
   localparam int MAX_OC = (OPEN_CYCLES > COOLDOWN_CYCLES) ? OPEN_CYCLES : COOLDOWN_CYCLES;
   localparam int MAX_V  = (MAX_HT > MAX_OC) ? MAX_HT : MAX_OC;
   localparam int CW     = $clog2(MAX_V + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(ARM_TIMEOUT - 1);
   localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_CYCLES - 1);
   localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);

   st_t           st;
   logic [CW-1:0] hold_cnt;
   logic [CW-1:0] tmo_cnt;
   logic [CW-1:0] ph_cnt;
   logic          ok;

   assign ok    = (t_lim >= t_act);
   assign state = st;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st         <= S_IDLE;
         hold_cnt   <= '0;
         tmo_cnt    <= '0;
         ph_cnt     <= '0;
         drop_en    <= 1'b0;
         hatch_open <= 1'b0;
         drop_done  <= 1'b0;
         timeout    <= 1'b0;
         busy       <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         drop_done <= 1'b0;
         timeout   <= 1'b0;
         case (st)
            S_IDLE: begin
               if (cmd_valid && cmd_drop && !cmd_abort) begin
                  st       <= S_ARMED;
                  hold_cnt <= '0;
                  tmo_cnt  <= '0;
                  drop_en  <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_ARMED: begin
               hold_cnt <= ok ? hold_cnt + 1'b1 : '0;
               tmo_cnt  <= tmo_cnt + 1'b1;
               // Abort outranks hold-met, which outranks timeout.
               if (cmd_valid && cmd_abort) begin
                  st      <= S_IDLE;
                  drop_en <= 1'b0;
                  busy    <= 1'b0;
               end else if (ok && hold_cnt == HOLD_LAST) begin
                  st         <= S_OPEN;
                  hatch_open <= 1'b1;
                  ph_cnt     <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  st      <= S_IDLE;
                  drop_en <= 1'b0;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end
            end
            S_OPEN: begin
               ph_cnt <= ph_cnt + 1'b1;
               if (ph_cnt == OPEN_LAST) begin
                  st         <= S_COOL;
                  ph_cnt     <= '0;
                  drop_en    <= 1'b0;
                  hatch_open <= 1'b0;
                  drop_done  <= 1'b1;
                  if (drop_count != 8'hFF)
                     drop_count <= drop_count + 8'd1;
               end
            end
            S_COOL: begin
               ph_cnt <= ph_cnt + 1'b1;
               if (ph_cnt == COOL_LAST) begin
                  st   <= S_IDLE;
                  busy <= 1'b0;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule
